rr_arb_4: RTL and testbench

RR_ARB_4 -- requirements
Module: rr_arb_4

---
 rtl/arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 27 ++
 rtl/rr_arb_4.sv | 102 ++++++++++
 tb/tb_rr_arb_4.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 4-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned HCNT_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating 4-to-2 priority encoder: first set req bit after ptr wins, ptr itself last.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             v
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest slot to the nearest so the slot right after ptr wins.
    always_comb begin
        idx  = '0;
        v    = 1'b0;
        cand = '0;
        for (int k = int'(N_REQ); k >= 1; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                idx = cand;
                v   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb_4.sv
// Four-requester round-robin arbiter with a bounded hold time and registered grant outputs.
module rr_arb_4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_id,
    output logic             gnt_v
);

    state_t              state, state_n;
    logic [IDX_W-1:0]    ptr, ptr_n;
    logic [HCNT_W-1:0]   hcnt, hcnt_n;
    logic [N_REQ-1:0]    gnt_n;
    logic [IDX_W-1:0]    gnt_id_n;
    logic                gnt_v_n;

    logic [IDX_W-1:0]    pick_idx;
    logic                pick_v;
    logic                release_c;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .v   (pick_v)
    );

    // Owner gives up the resource when it stops asking or its hold budget is spent.
    assign release_c = (state == GRANT) &&
                       (!req[gnt_id] || (hcnt == HCNT_W'(MAX_HOLD)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= IDX_W'(N_REQ - 1);
            hcnt   <= '0;
            gnt    <= '0;
            gnt_id <= '0;
            gnt_v  <= 1'b0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            hcnt   <= hcnt_n;
            gnt    <= gnt_n;
            gnt_id <= gnt_id_n;
            gnt_v  <= gnt_v_n;
        end
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        hcnt_n   = hcnt;
        gnt_n    = gnt;
        gnt_id_n = gnt_id;
        gnt_v_n  = gnt_v;

        unique case (state)
            IDLE: begin
                if (pick_v) begin
                    state_n         = GRANT;
                    ptr_n           = pick_idx;
                    hcnt_n          = HCNT_W'(1);
                    gnt_n           = '0;
                    gnt_n[pick_idx] = 1'b1;
                    gnt_id_n        = pick_idx;
                    gnt_v_n         = 1'b1;
                end
            end
            GRANT: begin
                if (!release_c) begin
                    hcnt_n = hcnt + HCNT_W'(1);
                end else if (pick_v) begin
                    // Hand over in the same edge; a lone owner is simply re-granted.
                    ptr_n           = pick_idx;
                    hcnt_n          = HCNT_W'(1);
                    gnt_n           = '0;
                    gnt_n[pick_idx] = 1'b1;
                    gnt_id_n        = pick_idx;
                    gnt_v_n         = 1'b1;
                end else begin
                    state_n  = IDLE;
                    gnt_n    = '0;
                    gnt_id_n = '0;
                    gnt_v_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    req_known_a : assert property (@(posedge clk) disable iff (rst) !$isunknown(req))
        else $error("rr_arb_4: X/Z value on req");

endmodule

// File: tb/tb_rr_arb_4.sv
// Self-checking bench for rr_arb_4: directed scenarios plus a model-scored random soak.
module tb_rr_arb_4;

    logic       clk = 1'b0;
    logic       rst    [2];
    logic [3:0] req    [2];
    logic [3:0] gnt    [2];
    logic [1:0] gnt_id [2];
    logic       gnt_v  [2];

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] sbq  [$];
    logic [3:0] sbq0 [$];
    logic [3:0] sbq1 [$];

    int         m_own [2];
    int         m_ptr [2];
    int         m_hc  [2];
    int         hold_run [2];
    int         waitc [2][4];
    logic [3:0] prev_g [2];

    always #5 clk = ~clk;

    rr_arb_4 #(.MAX_HOLD(4)) dut_a (
        .clk(clk), .rst(rst[0]), .req(req[0]),
        .gnt(gnt[0]), .gnt_id(gnt_id[0]), .gnt_v(gnt_v[0])
    );

    rr_arb_4 #(.MAX_HOLD(1)) dut_b (
        .clk(clk), .rst(rst[1]), .req(req[1]),
        .gnt(gnt[1]), .gnt_id(gnt_id[1]), .gnt_v(gnt_v[1])
    );

    function automatic int mh(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic logic [1:0] enc(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst[0] = 1'b1; rst[1] = 1'b1;
        req[0] = 4'b0; req[1] = 4'b0;
        tick();
        rst[0] = 1'b0; rst[1] = 1'b0;
    endtask

    // Reference arbiter: behaviour written straight from the selection/hold rules.
    task automatic model_step(input int d, input logic rs, input logic [3:0] rq,
                              output logic [3:0] g);
        int w;
        if (rs) begin
            m_own[d] = -1; m_ptr[d] = 3; m_hc[d] = 0;
        end else if (m_own[d] >= 0 && rq[2'(m_own[d])] && m_hc[d] < mh(d)) begin
            m_hc[d]++;
        end else begin
            w = -1;
            for (int k = 1; k <= 4; k++)
                if (w < 0 && rq[2'((m_ptr[d] + k) % 4)]) w = (m_ptr[d] + k) % 4;
            if (w >= 0) begin
                m_own[d] = w; m_ptr[d] = w; m_hc[d] = 1;
            end else begin
                m_own[d] = -1;
            end
        end
        g = (m_own[d] < 0) ? 4'b0 : 4'(1 << m_own[d]);
    endtask

    task automatic test_reset();
        logic [3:0] want;
        rst[0] = 1'b1; rst[1] = 1'b1;
        req[0] = 4'b1111; req[1] = 4'b1111;
        sbq.push_back(4'b0000);
        tick();
        want = sbq.pop_front();
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (gnt[d] !== want || gnt_id[d] !== 2'd0 || gnt_v[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset[dut%0d]: gnt=%b id=%0d v=%b, want gnt=%b id=0 v=0",
                         d, gnt[d], gnt_id[d], gnt_v[d], want);
            end
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
    endtask

    task automatic test_hold_rotation();
        logic [3:0] rq  [10] = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101,
                                 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0000};
        logic [3:0] exp [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100,
                                 4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0000};
        logic [3:0] want;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            sbq.push_back(exp[i]);
            req[0] = rq[i];
            tick();
            want = sbq.pop_front();
            n_tests++;
            if (gnt[0] !== want || gnt_id[0] !== enc(want) || gnt_v[0] !== (want != 4'b0)) begin
                n_fail++;
                $display("FAIL hold_rotation[%0d]: gnt=%b id=%0d v=%b, want gnt=%b id=%0d v=%b",
                         i, gnt[0], gnt_id[0], gnt_v[0], want, enc(want), want != 4'b0);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] rq  [7] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000};
        logic [3:0] exp [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0000};
        logic [3:0] want;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            sbq.push_back(exp[i]);
            req[1] = rq[i];
            tick();
            want = sbq.pop_front();
            n_tests++;
            if (gnt[1] !== want || gnt_id[1] !== enc(want) || gnt_v[1] !== (want != 4'b0)) begin
                n_fail++;
                $display("FAIL round_robin[%0d]: gnt=%b id=%0d v=%b, want gnt=%b id=%0d v=%b",
                         i, gnt[1], gnt_id[1], gnt_v[1], want, enc(want), want != 4'b0);
            end
        end
    endtask

    task automatic test_voluntary_handoff();
        logic [3:0] rq  [5] = '{4'b0100, 4'b0100, 4'b1001, 4'b1001, 4'b0000};
        logic [3:0] exp [5] = '{4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0000};
        logic [3:0] want;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            sbq.push_back(exp[i]);
            req[0] = rq[i];
            tick();
            want = sbq.pop_front();
            n_tests++;
            if (gnt[0] !== want || gnt_id[0] !== enc(want) || gnt_v[0] !== (want != 4'b0)) begin
                n_fail++;
                $display("FAIL voluntary_handoff[%0d]: gnt=%b id=%0d v=%b, want gnt=%b id=%0d v=%b",
                         i, gnt[0], gnt_id[0], gnt_v[0], want, enc(want), want != 4'b0);
            end
        end
    endtask

    // After owner 1 leaves, the search starts at 2 and wraps to 0 before 1.
    task automatic test_idle_wrap();
        logic [3:0] rq  [9] = '{4'b0010, 4'b0000, 4'b0000, 4'b0011, 4'b0011,
                                4'b0011, 4'b0011, 4'b0011, 4'b0000};
        logic [3:0] exp [9] = '{4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b0001,
                                4'b0001, 4'b0001, 4'b0010, 4'b0000};
        logic [3:0] want;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            sbq.push_back(exp[i]);
            req[0] = rq[i];
            tick();
            want = sbq.pop_front();
            n_tests++;
            if (gnt[0] !== want || gnt_id[0] !== enc(want) || gnt_v[0] !== (want != 4'b0)) begin
                n_fail++;
                $display("FAIL idle_wrap[%0d]: gnt=%b id=%0d v=%b, want gnt=%b id=%0d v=%b",
                         i, gnt[0], gnt_id[0], gnt_v[0], want, enc(want), want != 4'b0);
            end
        end
    endtask

    task automatic test_no_preempt();
        logic [3:0] rq  [7] = '{4'b0001, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000};
        logic [3:0] exp [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0000};
        logic [3:0] want;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            sbq.push_back(exp[i]);
            req[0] = rq[i];
            tick();
            want = sbq.pop_front();
            n_tests++;
            if (gnt[0] !== want || gnt_id[0] !== enc(want) || gnt_v[0] !== (want != 4'b0)) begin
                n_fail++;
                $display("FAIL no_preempt[%0d]: gnt=%b id=%0d v=%b, want gnt=%b id=%0d v=%b",
                         i, gnt[0], gnt_id[0], gnt_v[0], want, enc(want), want != 4'b0);
            end
        end
    endtask

    task automatic test_forced_regrant();
        logic [3:0] rq  [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0000};
        logic [3:0] exp [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0000};
        logic [3:0] want;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            sbq.push_back(exp[i]);
            req[1] = rq[i];
            tick();
            want = sbq.pop_front();
            n_tests++;
            if (gnt[1] !== want || gnt_id[1] !== enc(want) || gnt_v[1] !== (want != 4'b0)) begin
                n_fail++;
                $display("FAIL forced_regrant[%0d]: gnt=%b id=%0d v=%b, want gnt=%b id=%0d v=%b",
                         i, gnt[1], gnt_id[1], gnt_v[1], want, enc(want), want != 4'b0);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        logic       rs  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] rq  [6] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
        logic [3:0] exp [6] = '{4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
        logic [3:0] want;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            sbq.push_back(exp[i]);
            rst[0] = rs[i];
            req[0] = rq[i];
            tick();
            want = sbq.pop_front();
            n_tests++;
            if (gnt[0] !== want || gnt_id[0] !== enc(want) || gnt_v[0] !== (want != 4'b0)) begin
                n_fail++;
                $display("FAIL reset_mid_grant[%0d]: gnt=%b id=%0d v=%b, want gnt=%b id=%0d v=%b",
                         i, gnt[0], gnt_id[0], gnt_v[0], want, enc(want), want != 4'b0);
            end
        end
        rst[0] = 1'b0;
    endtask

    task automatic test_soak();
        logic [3:0] nr, want;
        logic       rs;
        int         worst;
        do_reset();
        for (int d = 0; d < 2; d++) begin
            m_own[d] = -1; m_ptr[d] = 3; m_hc[d] = 0;
            hold_run[d] = 0; prev_g[d] = 4'b0;
            for (int i = 0; i < 4; i++) waitc[d][i] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            for (int d = 0; d < 2; d++) begin
                nr = req[d] ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
                rs = ($urandom_range(0, 999) == 0);
                model_step(d, rs, nr, want);
                if (d == 0) sbq0.push_back(want); else sbq1.push_back(want);
                rst[d] = rs;
                req[d] = nr;
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                want = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
                n_tests++;
                if (gnt[d] !== want) begin
                    n_fail++;
                    $display("FAIL soak_grant[dut%0d cyc %0d]: gnt=%b, want %b", d, c, gnt[d], want);
                end
                n_tests++;
                if (!$onehot0(gnt[d]) || gnt_id[d] !== enc(gnt[d]) || gnt_v[d] !== (gnt[d] != 4'b0)) begin
                    n_fail++;
                    $display("FAIL soak_encode[dut%0d cyc %0d]: gnt=%b id=%0d v=%b, want one-hot with matching id/v",
                             d, c, gnt[d], gnt_id[d], gnt_v[d]);
                end
                // A lone requester may be re-granted, so a hold run restarts when nobody else asked.
                if (gnt[d] == 4'b0) hold_run[d] = 0;
                else if (gnt[d] != prev_g[d]) hold_run[d] = 1;
                else if ((req[d] & ~gnt[d]) == 4'b0) hold_run[d] = 1;
                else hold_run[d]++;
                prev_g[d] = gnt[d];
                n_tests++;
                if (hold_run[d] > mh(d)) begin
                    n_fail++;
                    $display("FAIL soak_hold[dut%0d cyc %0d]: held %0d cycles, want <= %0d",
                             d, c, hold_run[d], mh(d));
                end
                worst = 0;
                for (int i = 0; i < 4; i++) begin
                    if (rst[d] || !req[d][i] || gnt[d][i]) waitc[d][i] = 0;
                    else waitc[d][i]++;
                    if (waitc[d][i] > worst) worst = waitc[d][i];
                end
                n_tests++;
                if (worst > 3 * mh(d) + 3) begin
                    n_fail++;
                    $display("FAIL soak_wait[dut%0d cyc %0d]: waited %0d cycles, want <= %0d",
                             d, c, worst, 3 * mh(d) + 3);
                end
            end
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
    endtask

    initial begin
        rst[0] = 1'b1; rst[1] = 1'b1;
        req[0] = 4'b0; req[1] = 4'b0;
        test_reset();
        test_hold_rotation();
        test_round_robin();
        test_voluntary_handoff();
        test_idle_wrap();
        test_no_preempt();
        test_forced_regrant();
        test_reset_mid_grant();
        test_soak();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1, "watchdog expired");
    end

endmodule
